// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 beside the M stage of the P7 pipelined MIPS core.
// Holds SR (12), Cause (13), EPC (14) and PRId (15), arbitrates interrupts
// against exceptions and raises Req to enter the handler.
//
// Parameters:
//   HW_INT_NUM  hardware interrupt lines (1..6), IP/IM bits 10..10+HW_INT_NUM-1
//   INT_LATCH   0 = level interrupts, 1 = sticky pending bits (W1C via mtc0 13)
//   PRID        constant returned by reg 15
//
// Optional feature macro: CP0_TIMER_EN adds Count (9) / Compare (11) and the
// timer interrupt TI at Cause[8], masked by SR[8].
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   CP0We        mtc0 write enable
//   CP0Add       register address for read and write
//   CP0In        mtc0 write data
//   VPC          victim PC of the M-stage instruction
//   BDIn         victim sits in a delay slot
//   ExcCodeIn    exception code from the pipeline, 0 = none
//   HWInt        hardware interrupt lines
//   EXLClr       eret, clears SR.EXL
//   CP0Out       combinational read data
//   EPCOut       current EPC
//   Req          combinational handler-entry request
module cp0_ctrl #(
  parameter int          HW_INT_NUM = 6,
  parameter int          INT_LATCH  = 0,
  parameter logic [31:0] PRID       = 32'h0000_4C00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CP0We,
  input  logic [4:0]            CP0Add,
  input  logic [31:0]           CP0In,
  input  logic [31:0]           VPC,
  input  logic                  BDIn,
  input  logic [4:0]            ExcCodeIn,
  input  logic [HW_INT_NUM-1:0] HWInt,
  input  logic                  EXLClr,
  output logic [31:0]           CP0Out,
  output logic [31:0]           EPCOut,
  output logic                  Req
);

  localparam int IMH = 10 + HW_INT_NUM - 1;

  logic [HW_INT_NUM-1:0] im;
  logic [HW_INT_NUM-1:0] ip;
  logic [HW_INT_NUM-1:0] pend;
  logic [HW_INT_NUM-1:0] eff;
  logic                  exl;
  logic                  ie;
  logic                  bd;
  logic [4:0]            exccode;
  logic [31:0]           epc;
  logic                  int_req;
  logic                  exc_req;
  logic                  tim_term;
  logic                  we_ok;
  logic                  we_sr;
  logic                  we_epc;
  logic [31:0]           sr_val;
  logic [31:0]           cause_val;

  // A Req edge swallows any mtc0 issued in the same cycle.
  assign we_ok  = CP0We & ~Req;
  assign we_sr  = we_ok & (CP0Add == 5'd12);
  assign we_epc = we_ok & (CP0Add == 5'd14);

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic        tim;

  assign tim_term = ti & tim;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 32'h0;
      compare <= 32'h0;
      ti      <= 1'b0;
      tim     <= 1'b0;
    end else begin
      count <= (we_ok && CP0Add == 5'd9) ? CP0In : count + 32'd1;
      if (we_ok && CP0Add == 5'd11) begin
        compare <= CP0In;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
      if (we_sr) tim <= CP0In[8];
    end
  end
`else
  assign tim_term = 1'b0;
`endif

  generate
    if (INT_LATCH != 0) begin : g_latch
      logic [HW_INT_NUM-1:0] pend_clr;
      assign pend_clr = (we_ok && CP0Add == 5'd13) ? CP0In[IMH:10] : '0;
      // Set beats clear when the line is still high during the W1C write.
      always_ff @(posedge clk) begin
        if (reset) pend <= '0;
        else       pend <= (pend & ~pend_clr) | HWInt;
      end
      assign eff = HWInt | pend;
    end else begin : g_level
      assign pend = '0;
      assign eff  = HWInt;
    end
  endgenerate

  assign int_req = ~exl & ie & ((|(eff & im)) | tim_term);
  assign exc_req = ~exl & (ExcCodeIn != 5'd0);
  assign Req     = int_req | exc_req;
  assign EPCOut  = epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      im      <= '0;
      ip      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      bd      <= 1'b0;
      exccode <= 5'd0;
      epc     <= 32'h0;
    end else begin
      ip <= eff;
      if (Req) begin
        exl     <= 1'b1;
        bd      <= BDIn;
        exccode <= int_req ? 5'd0 : ExcCodeIn;
        epc     <= BDIn ? VPC - 32'd4 : VPC;
      end else begin
        // eret wins over an SR write's EXL bit but the rest of the write lands.
        if (we_sr) begin
          im  <= CP0In[IMH:10];
          ie  <= CP0In[0];
          exl <= CP0In[1] & ~EXLClr;
        end else if (EXLClr) begin
          exl <= 1'b0;
        end
        if (we_epc) epc <= {CP0In[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    sr_val           = 32'h0;
    sr_val[IMH:10]   = im;
    sr_val[1]        = exl;
    sr_val[0]        = ie;
    cause_val        = 32'h0;
    cause_val[31]    = bd;
    cause_val[IMH:10] = ip;
    cause_val[6:2]   = exccode;
`ifdef CP0_TIMER_EN
    sr_val[8]        = tim;
    cause_val[8]     = ti;
`endif
    case (CP0Add)
      5'd12:   CP0Out = sr_val;
      5'd13:   CP0Out = cause_val;
      5'd14:   CP0Out = epc;
      5'd15:   CP0Out = PRID;
`ifdef CP0_TIMER_EN
      5'd9:    CP0Out = count;
      5'd11:   CP0Out = compare;
`endif
      default: CP0Out = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
module tb_cp0_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, bd_in, exlclr;
  logic [4:0]  addr, exc;
  logic [31:0] din, vpc;
  logic [5:0]  hw;
  logic [1:0]  req_o;
  logic [63:0] out_o, epc_o;

  int total = 0;
  int bad   = 0;

`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  // dut0: 6 level lines; dut1: 3 sticky lines. Both see the same stimulus.
  cp0_ctrl #(.HW_INT_NUM(6), .INT_LATCH(0)) dut0 (
    .clk(clk), .reset(rst), .CP0We(we), .CP0Add(addr), .CP0In(din),
    .VPC(vpc), .BDIn(bd_in), .ExcCodeIn(exc), .HWInt(hw), .EXLClr(exlclr),
    .CP0Out(out_o[31:0]), .EPCOut(epc_o[31:0]), .Req(req_o[0]));

  cp0_ctrl #(.HW_INT_NUM(3), .INT_LATCH(1)) dut1 (
    .clk(clk), .reset(rst), .CP0We(we), .CP0Add(addr), .CP0In(din),
    .VPC(vpc), .BDIn(bd_in), .ExcCodeIn(exc), .HWInt(hw[2:0]), .EXLClr(exlclr),
    .CP0Out(out_o[63:32]), .EPCOut(epc_o[63:32]), .Req(req_o[1]));

  // Reference model: architectural register values per instance.
  logic [31:0] m_sr[2], m_epc[2], m_cnt[2], m_cmp[2];
  logic        m_bd[2], m_ti[2];
  logic [5:0]  m_ip[2], m_pend[2];
  logic [4:0]  m_exc[2];

  function automatic logic [5:0] nmask(int k);
    return (k == 0) ? 6'h3F : 6'h07;
  endfunction

  function automatic logic [31:0] wmask(int k);
    logic [31:0] m;
    m = 32'h3;
    m[15:10] = nmask(k);
    if (TIMER) m[8] = 1'b1;
    return m;
  endfunction

  function automatic logic [5:0] m_eff(int k);
    return (hw & nmask(k)) | ((k == 1) ? m_pend[k] : 6'h00);
  endfunction

  function automatic logic m_int(int k);
    logic [5:0] im;
    im = m_sr[k][15:10];
    return !m_sr[k][1] && m_sr[k][0] &&
           ((|(m_eff(k) & im)) || (TIMER && m_ti[k] && m_sr[k][8]));
  endfunction

  function automatic logic m_req(int k);
    return m_int(k) || (!m_sr[k][1] && exc != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(int k, logic [4:0] a);
    logic [31:0] c;
    c = 32'h0;
    c[31]    = m_bd[k];
    c[15:10] = m_ip[k];
    c[6:2]   = m_exc[k];
    if (TIMER) c[8] = m_ti[k];
    case (a)
      5'd12:   return m_sr[k];
      5'd13:   return c;
      5'd14:   return m_epc[k];
      5'd15:   return 32'h0000_4C00;
      5'd9:    return TIMER ? m_cnt[k] : 32'h0;
      5'd11:   return TIMER ? m_cmp[k] : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_step(int k);
    logic r, ir, wc;
    logic [5:0] e, clr;
    r  = m_req(k);
    ir = m_int(k);
    e  = m_eff(k);
    if (rst) begin
      m_sr[k] = 0; m_epc[k] = 0; m_cnt[k] = 0; m_cmp[k] = 0;
      m_bd[k] = 0; m_ti[k] = 0; m_ip[k] = 0; m_pend[k] = 0; m_exc[k] = 0;
      return;
    end
    wc = we && !r;
    m_ip[k] = e;
    if (k == 1) begin
      clr = (wc && addr == 5'd13) ? (din[15:10] & nmask(k)) : 6'h00;
      m_pend[k] = (m_pend[k] & ~clr) | (hw & nmask(k));
    end
    if (wc && addr == 5'd11) m_ti[k] = 1'b0;
    else if (m_cnt[k] == m_cmp[k]) m_ti[k] = 1'b1;
    m_cnt[k] = (wc && addr == 5'd9) ? din : m_cnt[k] + 1;
    if (wc && addr == 5'd11) m_cmp[k] = din;
    if (r) begin
      m_sr[k][1] = 1'b1;
      m_bd[k]    = bd_in;
      m_exc[k]   = ir ? 5'd0 : exc;
      m_epc[k]   = bd_in ? vpc - 32'd4 : vpc;
    end else begin
      if (we && addr == 5'd12) m_sr[k] = din & wmask(k);
      if (exlclr) m_sr[k][1] = 1'b0;
      if (we && addr == 5'd14) m_epc[k] = din & ~32'h3;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pre();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_req%0d a=%0d", k, addr), {31'b0, req_o[k]}, {31'b0, m_req(k)});
      chk($sformatf("model_out%0d a=%0d", k, addr), out_o[k*32 +: 32], m_read(k, addr));
      chk($sformatf("model_epc%0d", k), epc_o[k*32 +: 32], m_epc[k]);
    end
  endtask

  task automatic clock();
    @(posedge clk);
    m_step(0);
    m_step(1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; we = 0; addr = 0; din = 0; vpc = 0; bd_in = 0; exc = 0; hw = 0; exlclr = 0;
    clock();
    rst = 0;
  endtask

  task automatic hs(logic w, logic [4:0] a, logic [31:0] d, logic [5:0] h, logic x);
    we = w; addr = a; din = d; hw = h; exlclr = x;
    vpc = 32'h7000; bd_in = 0; exc = 0;
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
    logic        b;
    logic [4:0]  e;
    logic [5:0]  h;
    logic        x;
    logic        exp_req;
    logic [31:0] exp_out;
  } vec_t;

  function automatic vec_t mk(logic w, logic [4:0] a, logic [31:0] d, logic [31:0] pc,
                              logic b, logic [4:0] e, logic [5:0] h, logic x,
                              logic r, logic [31:0] o);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.pc = pc; v.b = b; v.e = e; v.h = h; v.x = x;
    v.exp_req = r; v.exp_out = o;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Expected Req / CP0Out of dut0 sampled before each edge.
    tbl.push_back(mk(1, 12, 32'h401,  0,       0, 0,  0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 12, 0,        32'h1000, 0, 0, 1, 0, 1, 32'h401));
    tbl.push_back(mk(0, 13, 0,        0,       0, 0,  0, 0, 0, 32'h400));
    tbl.push_back(mk(0, 12, 0,        0,       0, 0,  0, 0, 0, 32'h403));
    tbl.push_back(mk(0, 14, 0,        0,       0, 0,  0, 0, 0, 32'h1000));
    tbl.push_back(mk(0, 12, 0,        0,       0, 0,  0, 1, 0, 32'h403));
    tbl.push_back(mk(1, 12, 0,        0,       0, 0,  0, 0, 0, 32'h401));
    tbl.push_back(mk(0, 13, 0,        32'h3010, 1, 12, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 13, 0,        0,       0, 0,  0, 0, 0, 32'h8000_0030));
    tbl.push_back(mk(0, 14, 0,        0,       0, 0,  0, 0, 0, 32'h300C));
    tbl.push_back(mk(0, 12, 0,        0,       0, 0,  0, 0, 0, 32'h2));
    tbl.push_back(mk(1, 12, 32'h403,  0,       0, 0,  1, 0, 0, 32'h2));
    tbl.push_back(mk(0, 12, 0,        0,       0, 0,  1, 1, 0, 32'h403));
    tbl.push_back(mk(0, 12, 0,        32'h2000, 0, 0, 1, 0, 1, 32'h401));
    tbl.push_back(mk(0, 14, 0,        0,       0, 0,  1, 1, 0, 32'h2000));
    tbl.push_back(mk(0, 12, 0,        0,       0, 0,  0, 0, 0, 32'h401));
    tbl.push_back(mk(0, 12, 0,        32'h2100, 0, 0, 1, 0, 1, 32'h401));
    tbl.push_back(mk(0, 12, 0,        0,       0, 0,  0, 1, 0, 32'h403));
    tbl.push_back(mk(0, 12, 0,        0,       0, 0,  0, 0, 0, 32'h401));
    tbl.push_back(mk(1, 14, 32'h5000, 32'h4000, 0, 0, 1, 0, 1, 32'h2100));
    tbl.push_back(mk(0, 14, 0,        0,       0, 0,  0, 1, 0, 32'h4000));
    tbl.push_back(mk(1, 14, 32'h5003, 0,       0, 0,  0, 0, 0, 32'h4000));
    tbl.push_back(mk(0, 14, 0,        0,       0, 0,  0, 0, 0, 32'h5000));
    tbl.push_back(mk(0, 15, 0,        0,       0, 0,  0, 0, 0, 32'h4C00));
    tbl.push_back(mk(0, 20, 0,        0,       0, 0,  0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 12, 32'h403,  0,       0, 0,  0, 1, 0, 32'h401));
    tbl.push_back(mk(0, 12, 0,        0,       0, 0,  0, 0, 0, 32'h401));

    @(negedge clk);
    do_reset();
    hs(0, 12, 0, 0, 0);
    #1;
    chk("reset_req0", {31'b0, req_o[0]}, 32'h0);
    chk("reset_sr0", out_o[31:0], 32'h0);
    chk("reset_epc0", epc_o[31:0], 32'h0);

    foreach (tbl[i]) begin
      we = tbl[i].w; addr = tbl[i].a; din = tbl[i].d; vpc = tbl[i].pc;
      bd_in = tbl[i].b; exc = tbl[i].e; hw = tbl[i].h; exlclr = tbl[i].x;
      pre();
      chk($sformatf("tbl%0d_req", i), {31'b0, req_o[0]}, {31'b0, tbl[i].exp_req});
      chk($sformatf("tbl%0d_out", i), out_o[31:0], tbl[i].exp_out);
      clock();
    end

    // Sticky pending bits on dut1.
    do_reset();
    hs(1, 12, 0, 6'h4, 0);         pre(); clock();
    hs(0, 13, 0, 0, 0);            pre(); chk("latch_hold1", out_o[63:32], 32'h1000); clock();
    hs(0, 13, 0, 0, 0);            pre(); chk("latch_hold2", out_o[63:32], 32'h1000); clock();
    hs(1, 12, 32'h1001, 0, 0);     pre(); chk("latch_noreq", {31'b0, req_o[1]}, 32'h0); clock();
    hs(0, 12, 0, 0, 0);            pre(); chk("latch_req", {31'b0, req_o[1]}, 32'h1); clock();
    hs(1, 13, 32'h1000, 0, 0);     pre(); clock();
    hs(0, 13, 0, 0, 0);            pre(); chk("latch_clr_lag", out_o[63:32], 32'h1000); clock();
    hs(0, 13, 0, 0, 0);            pre(); chk("latch_cleared", out_o[63:32], 32'h0); clock();
    hs(1, 13, 32'h1000, 6'h4, 0);  pre(); clock();
    hs(0, 13, 0, 0, 0);            pre(); clock();
    hs(0, 13, 0, 0, 0);            pre(); chk("latch_set_wins", out_o[63:32], 32'h1000); clock();

`ifdef CP0_TIMER_EN
    begin
      bit seen;
      do_reset();
      hs(1, 11, 32'd5, 0, 0);      pre(); clock();
      hs(1, 9, 32'd0, 0, 0);       pre(); clock();
      hs(1, 12, 32'h101, 0, 0);    pre(); clock();
      seen = 0;
      for (int n = 0; n < 12 && !seen; n++) begin
        hs(0, 9, 0, 0, 0);
        pre();
        if (req_o[0]) begin
          seen = 1;
          chk("timer_count_at_req", out_o[31:0], 32'd6);
        end
        clock();
      end
      chk("timer_req_seen", {31'b0, seen}, 32'h1);
      hs(1, 11, 32'd100, 0, 0);    pre(); clock();
      hs(0, 13, 0, 0, 0);          pre(); chk("timer_ti_clr", {31'b0, out_o[8]}, 32'h0); clock();
      hs(1, 9, 32'hFFFF_FFFF, 0, 0); pre(); clock();
      hs(0, 9, 0, 0, 0);           pre(); chk("timer_max", out_o[31:0], 32'hFFFF_FFFF); clock();
      hs(0, 9, 0, 0, 0);           pre(); chk("timer_wrap", out_o[31:0], 32'h0); clock();
    end
`endif

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      we  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       addr = 5'd9;
        1:       addr = 5'd11;
        2, 3:    addr = 5'd12;
        4:       addr = 5'd13;
        5:       addr = 5'd14;
        6:       addr = 5'd15;
        default: addr = 5'($urandom);
      endcase
      din = $urandom;
      if ($urandom_range(0, 1) == 1) din[1] = 1'b0;
      vpc    = $urandom;
      bd_in  = 1'($urandom_range(0, 1));
      exc    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      if ($urandom_range(0, 2) == 0) hw = 6'($urandom);
      exlclr = ($urandom_range(0, 3) == 0);
      pre();
      clock();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
